riscv_trace_buffer: RTL
=======================

# riscv_trace_buffer

Retirement/memory trace capture stage sitting directly downstream of the `riscv` core top. It samples the core's observation outputs (register write-back and data-memory access strobes) every cycle and packs each active cycle into one trace entry with a free-running cycle stamp. Entries go into a FIFO that drains over a valid/ready port to a debug sink (bench monitor or UART/JTAG dumper). Overflow is detected, counted and flagged rather than back-pressuring the core, which has no stall input.

## Interface
- `DATA_W`, 32, data width of register and memory data fields.
- `ADDR_W`, 9, memory address width; matches the core's `addr`.
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `trace_en`  in  1  capture enable; 0 means no pushes.
- `reg_write_sig`  in  1  core register write strobe.
- `reg_num`  in  5  destination register.
- `reg_data`  in  DATA_W  write-back value.
- `wr`  in  1  data-memory write strobe.
- `rd`  in  1  data-memory read strobe.
- `addr`  in  ADDR_W  memory address.
- `wr_data`  in  DATA_W  store data.
- `rd_data`  in  DATA_W  load data.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  sink accepts head.
- `out_entry`  out  `trace_entry_t`  head entry.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; at least one entry dropped.
- `drop_cnt`  out  16  dropped entries, saturating at 16'hFFFF.
- `clr_ovf`  in  1  synchronous clear of `overflow` and `drop_cnt`.

## Operation
- Event: `trace_en && (reg_write_sig || wr || rd)` in a cycle. Produces exactly one entry.
- Entry fields:
  - `flags` = {reg_write_sig, wr, rd}.
  - `rnum`/`rdata` = `reg_num`/`reg_data` if `reg_write_sig`, else 0.
  - `maddr` = `addr` if `wr || rd`, else 0.
  - `mdata` = `wr_data` if `wr`, else `rd_data` if `rd`, else 0. If `wr && rd` both flags are set and `mdata` = `wr_data`.
  - `stamp` = cycle counter value in the event cycle.
- Cycle counter: 32-bit, increments every cycle after reset, wraps 32'hFFFFFFFF -> 0. It is not gated by `trace_en`.
- Pop: `out_valid && out_ready`.
- Push when not full: entry written at tail.
- Push when full and no pop this cycle: entry dropped, `overflow` <= 1, `drop_cnt` increments (saturating).
- Push when full with pop this cycle: the push is accepted and nothing is dropped.
- `clr_ovf` with a simultaneous drop: result is `overflow`=1, `drop_cnt`=1.
- Push with pop on a non-empty FIFO: `level` is unchanged.
- Pointers wrap modulo DEPTH.
- `out_entry` is undefined (don't-care) when `out_valid`=0. The bench must not check it.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, cycle counter=0.
  - `out_entry` is all-zero.
- Latency: an event in cycle N raises `out_valid` in cycle N+1 if the FIFO was empty. There is no combinational input-to-output path.
- `out_valid` is stable until the pop. `out_entry` is stable while `out_valid && !out_ready`.
- `level` and `overflow` update at the clock edge following the causing event.
- Reset asserted mid-operation flushes all entries and clears all state asynchronously. The first cycle after deassertion has stamp 0.

## Structure
- `trace_pkg` holds:
  - `trace_entry_t` (struct packed: `flags`[2:0], `rnum`[4:0], `rdata`, `maddr`, `mdata`, `stamp`[31:0]).
  - Flag bit index constants `TR_RW`, `TR_MW`, `TR_MR`.
- One sub-module, `trace_fifo`: a generic synchronous FIFO over `trace_entry_t` with push/pop, full/empty and level.
- Packing, the cycle counter and overflow accounting live in `riscv_trace_buffer`.

## Test plan
- Reset, then `reg_write_sig`=1, `reg_num`=5, `reg_data`=32'h0000_002A at cycle 3, `out_ready`=1 -> one entry with flags=3'b100, rnum=5, rdata=32'h2A, stamp=3, `out_valid` high for exactly one cycle.
- Store with `wr`=1, `addr`=9'h010, `wr_data`=32'hDEADBEEF in the same cycle as a register write x7=1 -> a single entry with flags=3'b110, maddr=9'h010, mdata=32'hDEADBEEF, rnum=7.
- `out_ready`=0 with 20 consecutive events at DEPTH=16 -> `level`=16, `overflow`=1, `drop_cnt`=4. The drained entries are the first 16 stamps, in order.
- FIFO full, then a push and a pop in the same cycle -> `drop_cnt` is unchanged and `level` stays 16. Then pulse `clr_ovf` -> `overflow`=0, `drop_cnt`=0.
- `trace_en`=0 during 10 loads -> no entries. Re-enable -> the next entry's stamp reflects the elapsed cycles, with no gap compensation.
- Assert `reset` with 5 entries queued and `out_ready` toggling randomly -> `out_valid`=0 and `level`=0 immediately. The next event after release carries the correct small stamp.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the trace capture path.
// trace_entry_t is one captured cycle: flags {reg write, mem write, mem read},
// register write-back fields, memory access fields and the cycle stamp.
// Data and address field widths are fixed here and must match the DATA_W and
// ADDR_W parameters of riscv_trace_buffer.
package trace_pkg;
  localparam int TR_DATA_W = 32;
  localparam int TR_ADDR_W = 9;

  // bit positions inside trace_entry_t.flags
  localparam int TR_RW = 2;
  localparam int TR_MW = 1;
  localparam int TR_MR = 0;

  typedef struct packed {
    logic [2:0]           flags;
    logic [4:0]           rnum;
    logic [TR_DATA_W-1:0] rdata;
    logic [TR_ADDR_W-1:0] maddr;
    logic [TR_DATA_W-1:0] mdata;
    logic [31:0]          stamp;
  } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace_entry_t.
// Ports: clk, reset (async, active high), push/din, pop/dout, full, empty, level.
// A push while full is accepted only when a pop happens in the same cycle.
// A pop while empty is ignored. dout reads as zero while the FIFO is empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  trace_entry_t             din,
  input  logic                     pop,
  output trace_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  trace_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           wr_en, rd_en;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  // The slot freed by a simultaneous pop lets a push into a full FIFO through.
  assign wr_en = push && (!full || rd_en);

  // Masking keeps the head at zero after reset without resetting storage.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/riscv_trace_buffer.sv
// Retirement / memory trace capture behind the core.
// Every cycle with trace_en and any of reg_write_sig/wr/rd becomes one entry,
// stamped with a free-running 32-bit cycle counter, and is queued in a FIFO
// drained over out_valid/out_ready. The core cannot stall, so a push into a
// full FIFO (with no pop that cycle) is dropped and accounted in the sticky
// overflow flag and the saturating drop_cnt; clr_ovf clears both.
// Ports: clk, reset (async, active high), trace_en, core observation strobes
// and data, out_valid/out_ready/out_entry, level, overflow, drop_cnt, clr_ovf.
module riscv_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output trace_entry_t             out_entry,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  input  logic                     clr_ovf
);
  logic [31:0]  cycle;
  logic         event_hit, pop, full, empty, drop;
  trace_entry_t entry;

  assign event_hit = trace_en && (reg_write_sig || wr || rd);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = event_hit && full && !pop;

  always_comb begin
    entry              = '0;
    entry.flags[TR_RW] = reg_write_sig;
    entry.flags[TR_MW] = wr;
    entry.flags[TR_MR] = rd;
    if (reg_write_sig) begin
      entry.rnum  = reg_num;
      entry.rdata = reg_data;
    end
    if (wr || rd) entry.maddr = addr;
    // a store wins the single data field when both strobes are set
    if (wr)      entry.mdata = wr_data;
    else if (rd) entry.mdata = rd_data;
    entry.stamp = cycle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle <= '0;
    else       cycle <= cycle + 32'd1;
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= 16'd1;
      else if (drop_cnt != '1)    drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (event_hit),
    .din   (entry),
    .pop   (pop),
    .dout  (out_entry),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule
